// File: rtl/sseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner.
// One digit per slot, with a one-cycle blank gap at each slot end.
module sseg_scan_driver #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   hex_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     en_in,
  output logic [6:0]              F,
  output logic [N_DIGITS-1:0]     AN,
  output logic                    DP
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [CW-1:0]       div_cnt;
  logic [IW-1:0]       digit_idx;
  logic                terminal;
  logic [3:0]          nib;
  logic [6:0]          seg;
  logic [N_DIGITS-1:0] one_cold;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    terminal = (div_cnt == DIV_LAST);
    nib      = hex_in[4*digit_idx +: 4];
    seg      = seg_decode(nib);
    one_cold = ~(N_DIGITS'(1) << digit_idx);
  end

  // Terminal cycle blanks everything so no anode overlaps a stale pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      digit_idx <= '0;
      AN        <= '1;
      F         <= 7'h7F;
      DP        <= 1'b1;
    end else if (terminal) begin
      div_cnt   <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      AN        <= '1;
      F         <= 7'h7F;
      DP        <= 1'b1;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
      AN        <= en_in[digit_idx] ? one_cold : '1;
      F         <= seg;
      DP        <= ~dp_in[digit_idx];
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with REFRESH_DIV=4, N_DIGITS=8.
// Samples 1 time unit after each rising edge.
`timescale 1ns/1ps
module tb_sseg_scan_driver;

  localparam int ND = 8;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4*ND-1:0] hex_in;
  logic [ND-1:0] dp_in;
  logic [ND-1:0] en_in;
  logic [6:0]    F;
  logic [ND-1:0] AN;
  logic          DP;

  int total = 0;
  int bad   = 0;

  logic [6:0] dec [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  sseg_scan_driver #(
    .N_DIGITS    (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .hex_in (hex_in),
    .dp_in  (dp_in),
    .en_in  (en_in),
    .F      (F),
    .AN     (AN),
    .DP     (DP)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold reset for n cycles, then release just after an edge.
  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // Advance through cycles first..last, checking the slot schedule.
  task automatic run_model(input int first, input int last,
                           input string tag);
    int pos, d;
    logic [ND-1:0] ean;
    logic [6:0]    ef;
    logic          edp;
    logic [3:0]    nb;
    for (int c = first; c <= last; c++) begin
      tick();
      pos = (c - 1) % RD;
      d   = ((c - 1) / RD) % ND;
      nb  = hex_in[4*d +: 4];
      if (pos == RD - 1) begin
        ean = '1;
        ef  = 7'h7F;
        edp = 1'b1;
      end else begin
        ean = en_in[d] ? ~(ND'(1) << d) : '1;
        ef  = dec[nb];
        edp = ~dp_in[d];
      end
      chk($sformatf("%s_an_c%0d", tag, c), 32'(AN), 32'(ean));
      chk($sformatf("%s_f_c%0d", tag, c), 32'(F), 32'(ef));
      chk($sformatf("%s_dp_c%0d", tag, c), 32'(DP), 32'(edp));
    end
  endtask

  initial begin
    int prev_cold;
    bit gap_seen;
    int zeros;

    hex_in = 32'h76543210;
    en_in  = 8'hFF;
    dp_in  = 8'h00;

    // Reset values
    do_reset(2);
    chk("rst_an", 32'(AN), 32'hFF);
    chk("rst_f", 32'(F), 32'h7F);
    chk("rst_dp", 32'(DP), 32'h1);

    // Basic scan with explicit landmarks
    tick();
    chk("c1_an", 32'(AN), 32'hFE);
    chk("c1_f", 32'(F), 32'h40);
    tick(); tick(); tick();
    chk("c4_an", 32'(AN), 32'hFF);
    chk("c4_f", 32'(F), 32'h7F);
    tick();
    chk("c5_an", 32'(AN), 32'hFD);
    chk("c5_f", 32'(F), 32'h79);
    run_model(6, 28, "scan");
    tick();
    chk("c29_an", 32'(AN), 32'h7F);
    chk("c29_f", 32'(F), 32'h78);
    run_model(30, 32, "scan");
    tick();
    chk("c33_an", 32'(AN), 32'hFE);
    chk("c33_f", 32'(F), 32'h40);

    // Nibble sweep on digit 0: one-cycle live latency
    for (int v = 0; v < 16; v++) begin
      do_reset(1);
      hex_in[3:0] = 4'(v);
      tick();
      chk($sformatf("sweep_f_%0d", v), 32'(F), 32'(dec[v]));
      hex_in[3:0] = 4'(15 - v);
      tick();
      chk($sformatf("sweep_chg_%0d", v), 32'(F), 32'(dec[15-v]));
    end
    hex_in = 32'h76543210;

    // Blanked digit 2
    en_in = 8'b1111_1011;
    do_reset(1);
    run_model(1, 8, "en");
    for (int c = 9; c <= 12; c++) begin
      tick();
      chk($sformatf("en_d2_an_c%0d", c), 32'(AN), 32'hFF);
    end
    run_model(13, 32, "en");
    en_in = 8'hFF;

    // Decimal point only on digit 7
    dp_in = 8'h80;
    do_reset(1);
    for (int c = 1; c <= 32; c++) begin
      tick();
      chk($sformatf("dp_c%0d", c), 32'(DP),
          32'((AN == 8'h7F) ? 1'b0 : 1'b1));
      if (c == 29) chk("dp_d7_low", 32'(DP), 32'h0);
      if (c == 32) chk("dp_blank", 32'(DP), 32'h1);
    end
    dp_in = 8'h00;

    // Anode invariant over 10 frames with varied enables
    en_in = 8'b1010_1101;
    do_reset(1);
    prev_cold = -1;
    gap_seen  = 1'b1;
    for (int c = 1; c <= 10 * ND * RD; c++) begin
      tick();
      zeros = 0;
      for (int k = 0; k < ND; k++) if (!AN[k]) zeros++;
      chk($sformatf("inv_onecold_c%0d", c), 32'(zeros <= 1), 32'h1);
      if (zeros == 0) begin
        gap_seen = 1'b1;
      end else begin
        if (prev_cold != -1 && 32'(AN) != prev_cold)
          chk($sformatf("inv_gap_c%0d", c), 32'(gap_seen), 32'h1);
        prev_cold = 32'(AN);
        gap_seen  = 1'b0;
      end
    end
    en_in = 8'hFF;

    // Reset mid-slot of digit 5
    do_reset(1);
    run_model(1, 22, "pre");
    chk("mid_d5_an", 32'(AN), 32'hDF);
    reset = 1'b1;
    tick();
    chk("mid_rst_an", 32'(AN), 32'hFF);
    chk("mid_rst_f", 32'(F), 32'h7F);
    chk("mid_rst_dp", 32'(DP), 32'h1);
    reset = 1'b0;
    tick();
    chk("post_c1_an", 32'(AN), 32'hFE);
    chk("post_c1_f", 32'(F), 32'h40);
    run_model(2, 33, "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
